// File: rtl/uart_asm_pkg.sv
// Shared definitions for the UART operand assembler: FSM state encodings and the
// inter-byte timeout length in clocks.
package uart_asm_pkg;

    typedef enum logic [1:0] {
        sRX_A  = 2'd0,
        sRX_B  = 2'd1,
        sVALID = 2'd2
    } asm_state_e;

    // Gap length in clocks. Evaluated in 64 bits because bits * clk_freq overflows 32 bits
    // at realistic clock rates.
    function automatic longint unsigned timeout_clks(input int unsigned bits,
                                                     input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
        longint unsigned prod;
        prod = longint'(bits) * longint'(clk_freq);
        return prod / longint'(baud_rate);
    endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// W-bit register that shifts one byte in at the LSB end per iShift, so the first byte
// received ends up as the MSByte. iClr zeroes it.
module byte_shift_reg #(
    parameter int W = 512
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iClr,
    input  logic         iShift,
    input  logic [7:0]   iByte,
    output logic [W-1:0] oData
);

    logic [W-1:0] data_q;

    // NOTE: the wide data register is reset on purpose, because the operands must read as zero
    // after reset and after a timeout; this is not a RAM, so the reset costs no macro.
    if (W == 8) begin : g_single
        always_ff @(posedge iClk) begin
            if (iRst || iClr) begin
                data_q <= '0;
            end else if (iShift) begin
                data_q <= iByte;
            end
        end
    end else begin : g_wide
        always_ff @(posedge iClk) begin
            if (iRst || iClr) begin
                data_q <= '0;
            end else if (iShift) begin
                data_q <= {data_q[W-9:0], iByte};
            end
        end
    end

    assign oData = data_q;

endmodule

// File: rtl/uart_operand_assembler.sv
// Packs the UART RX byte stream into operands A then B and offers them on valid/ready.
// Optional inter-byte gap timeout is enabled with `define UART_ASM_TIMEOUT_EN.
module uart_operand_assembler
    import uart_asm_pkg::*;
#(
    parameter int OPERAND_WIDTH = 512,
    parameter int CLK_FREQ      = 125_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [7:0]               iRxByte,
    input  logic                     iRxDone,
    output logic [OPERAND_WIDTH-1:0] oOpA,
    output logic [OPERAND_WIDTH-1:0] oOpB,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oBusy,
    output logic                     oOverrun,
    output logic                     oTimeout
);

    localparam int              NBYTES   = OPERAND_WIDTH / 8;
    localparam int              CNT_W    = $clog2(NBYTES) + 1;
    localparam longint unsigned TMO_CLKS = timeout_clks(TIMEOUT_BITS, CLK_FREQ, BAUD_RATE);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    if (OPERAND_WIDTH < 8 || (OPERAND_WIDTH % 8) != 0 || TMO_CLKS < 1) begin : g_bad_cfg
        $error("uart_operand_assembler: bad OPERAND_WIDTH or timeout configuration");
    end

    asm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             shift_a, shift_b;
    logic             busy;
    logic             tmo_expire;

    assign busy = (state_q != sRX_A) || (cnt_q != '0);

`ifdef UART_ASM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

    logic [TMO_W-1:0] gap_q, gap_d;
    logic             timeout_q;

    // A byte strobe in the expiry cycle takes priority over the timeout.
    assign tmo_expire = busy && (state_q != sVALID) && !iRxDone && (gap_q == TMO_LAST);

    always_comb begin
        gap_d = gap_q;
        if (iRxDone || !busy || tmo_expire) begin
            gap_d = '0;
        end else if (state_q != sVALID) begin
            gap_d = gap_q + TMO_W'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            gap_q     <= gap_d;
            timeout_q <= tmo_expire;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign tmo_expire = 1'b0;
    assign oTimeout   = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_a   = 1'b0;
        shift_b   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            sRX_A: begin
                if (iRxDone) begin
                    shift_a = 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = sRX_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            sRX_B: begin
                if (iRxDone) begin
                    shift_b = 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = sVALID;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            sVALID: begin
                // Operands are frozen here; any arriving byte is dropped and flagged.
                overrun_d = iRxDone;
                if (iReady) begin
                    state_d = sRX_A;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = sRX_A;
                cnt_d   = '0;
            end
        endcase
        if (tmo_expire) begin
            state_d = sRX_A;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= sRX_A;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    byte_shift_reg #(.W(OPERAND_WIDTH)) u_reg_a (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (tmo_expire),
        .iShift (shift_a),
        .iByte  (iRxByte),
        .oData  (oOpA)
    );

    byte_shift_reg #(.W(OPERAND_WIDTH)) u_reg_b (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (tmo_expire),
        .iShift (shift_b),
        .iByte  (iRxByte),
        .oData  (oOpB)
    );

    assign oValid   = (state_q == sVALID);
    assign oBusy    = busy;
    assign oOverrun = overrun_q;

endmodule
